// File: rtl/demux_1x16_seq_if.sv
// Bundles the beat input, frame output and status signals of the 1-to-16 demux/assembler.
// The master drives beats and out_ready; the slave drives in_ready, the frame and status.
interface demux_1x16_seq_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             data_in;
    logic [SEL_W-1:0] select_line;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] output_data;
    logic [WIDTH-1:0] slot_mask;
    logic             dup_err;

    modport master (
        output flush, in_valid, data_in, select_line, out_ready,
        input  in_ready, out_valid, output_data, slot_mask, dup_err
    );

    modport slave (
        input  flush, in_valid, data_in, select_line, out_ready,
        output in_ready, out_valid, output_data, slot_mask, dup_err
    );
endinterface

// File: rtl/demux_1x16_seq.sv
// Routes each accepted serial bit into a slot of a WIDTH-bit frame and emits the frame once every slot is written.
// Latency: beat that completes the mask is accepted at edge N; out_valid and the frame are visible right after edge N.
// Backpressure: in_ready drops while a finished frame waits in HOLD; beats are refused until out_valid && out_ready.
module demux_1x16_seq #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    demux_1x16_seq_if.slave  bus
);
    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic             vld_q, vld_d;
    logic             dup_q, dup_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_base, shadow_base;
    logic [WIDTH-1:0] mask_upd, shadow_upd;
    logic             accept;

    // rdy_q is only ever set while in COLLECT, so it alone qualifies a beat
    assign accept = bus.in_valid && rdy_q;

    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        vld_d       = vld_q;
        dup_d       = 1'b0;
        mask_d      = mask_q;
        shadow_d    = shadow_q;
        data_d      = data_q;
        mask_base   = mask_q;
        shadow_base = shadow_q;
        mask_upd    = mask_q;
        shadow_upd  = shadow_q;

        case (state_q)
            COLLECT: begin
                rdy_d = 1'b1;
                // flush clears first so a same-cycle beat lands in a fresh frame
                if (bus.flush) begin
                    mask_base   = '0;
                    shadow_base = '0;
                end
                mask_upd   = mask_base;
                shadow_upd = shadow_base;
                if (accept) begin
                    dup_d                       = mask_base[bus.select_line];
                    mask_upd[bus.select_line]   = 1'b1;
                    shadow_upd[bus.select_line] = bus.data_in;
                end
                mask_d   = mask_upd;
                shadow_d = shadow_upd;
                if (accept && (&mask_upd)) begin
                    data_d   = shadow_upd;
                    vld_d    = 1'b1;
                    rdy_d    = 1'b0;
                    mask_d   = '0;
                    shadow_d = '0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                rdy_d = 1'b0;
                if (bus.out_ready) begin
                    vld_d   = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                rdy_d   = 1'b0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= COLLECT;
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
            dup_q    <= 1'b0;
            mask_q   <= '0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            vld_q    <= vld_d;
            dup_q    <= dup_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
        end
    end

    assign bus.in_ready    = rdy_q;
    assign bus.out_valid   = vld_q;
    assign bus.output_data = data_q;
    assign bus.slot_mask   = mask_q;
    assign bus.dup_err     = dup_q;
endmodule

// File: tb/tb_demux_1x16_seq.sv
// Directed bench for demux_1x16_seq: a stimulus-side model pushes finished frames to a queue,
// and a negedge monitor pops and compares them at each output handshake.
module tb_demux_1x16_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] mdl_mask = '0;
    logic [15:0] mdl_shadow = '0;
    logic [15:0] exp_q[$];

    demux_1x16_seq_if #(.WIDTH(16), .SEL_W(4)) bus ();

    demux_1x16_seq #(.WIDTH(16), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshake happens at the next posedge; out_ready is driven only just after posedges
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0)
                chk("frame_unexpected", {16'h0, bus.output_data}, 32'hDEAD_BEEF);
            else
                chk("frame_data", {16'h0, bus.output_data}, {16'h0, exp_q.pop_front()});
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_output_data", bus.output_data, 0);
        chk("rst_slot_mask", bus.slot_mask, 0);
        chk("rst_dup_err", bus.dup_err, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        mdl_mask     = '0;
        mdl_shadow   = '0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", bus.in_ready, 1);
    endtask

    task automatic beat(input logic [3:0] s, input logic d, input logic fl, output int waited);
        logic exp_dup;
        logic full;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("beat_in_ready", bus.in_ready, 1);
        bus.in_valid    = 1'b1;
        bus.select_line = s;
        bus.data_in     = d;
        bus.flush       = fl;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        if (fl) begin
            mdl_mask   = '0;
            mdl_shadow = '0;
        end
        exp_dup       = mdl_mask[s];
        mdl_mask[s]   = 1'b1;
        mdl_shadow[s] = d;
        full          = &mdl_mask;
        if (full) begin
            exp_q.push_back(mdl_shadow);
            mdl_mask   = '0;
            mdl_shadow = '0;
        end
        chk("beat_dup_err", bus.dup_err, exp_dup);
        chk("beat_slot_mask", bus.slot_mask, mdl_mask);
        chk("beat_out_valid", bus.out_valid, full);
        chk("beat_in_ready_after", bus.in_ready, !full);
    endtask

    initial begin
        logic [15:0] pat;
        int          w;
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pat;
        int          w;
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.data_in     = 1'b0;
        bus.select_line = '0;
        bus.out_ready   = 1'b1;
        #2;
        do_reset();

        // 1: ascending slots, 0xAAAA
        pat = 16'hAAAA;
        for (int i = 0; i < 16; i++) beat(i[3:0], pat[i], 1'b0, w);
        chk("t1_frame", bus.output_data, 16'hAAAA);
        @(posedge clk);
        #1;
        chk("t1_out_valid_drop", bus.out_valid, 0);
        chk("t1_data_kept", bus.output_data, 16'hAAAA);

        // 2: descending slots, 0xCCCC, held by out_ready=0 with a pending beat offered
        bus.out_ready = 1'b0;
        pat = 16'hCCCC;
        for (int i = 15; i >= 0; i--) beat(i[3:0], pat[i], 1'b0, w);
        bus.in_valid    = 1'b1;
        bus.select_line = 4'd0;
        bus.data_in     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("t2_hold_data", bus.output_data, 16'hCCCC);
            chk("t2_hold_valid", bus.out_valid, 1);
            chk("t2_hold_in_ready", bus.in_ready, 0);
            chk("t2_hold_mask", bus.slot_mask, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t2_release_valid", bus.out_valid, 0);
        chk("t2_release_in_ready", bus.in_ready, 1);
        chk("t2_no_beat_in_handshake", bus.slot_mask, 0);
        chk("t2_data_kept", bus.output_data, 16'hCCCC);
        bus.in_valid = 1'b0;

        // 3: duplicate write to slot 5 overwrites the bit
        beat(4'd5, 1'b1, 1'b0, w);
        beat(4'd5, 1'b0, 1'b0, w);
        for (int i = 0; i < 16; i++)
            if (i != 5) beat(i[3:0], 1'b1, 1'b0, w);
        chk("t3_frame", bus.output_data, 16'hFFDF);
        @(posedge clk);
        #1;

        // 4: flush together with a beat restarts the frame with just that slot
        for (int i = 0; i < 8; i++) beat(i[3:0], 1'b0, 1'b0, w);
        beat(4'd3, 1'b1, 1'b1, w);
        chk("t4_mask_after_flush", bus.slot_mask, 16'h0008);
        for (int i = 15; i >= 0; i--)
            if (i != 3) beat(i[3:0], i[0], 1'b0, w);
        chk("t4_frame", bus.output_data, 16'hAAAA | 16'h0008);
        @(posedge clk);
        #1;

        // 5a: reset during the 10th beat
        for (int i = 0; i < 9; i++) beat(i[3:0], 1'b1, 1'b0, w);
        bus.in_valid    = 1'b1;
        bus.select_line = 4'd9;
        bus.data_in     = 1'b1;
        @(negedge clk);
        do_reset();
        // 5b: reset while a frame waits in HOLD
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) beat(i[3:0], 1'b1, 1'b0, w);
        chk("t5_hold_valid", bus.out_valid, 1);
        do_reset();
        bus.out_ready = 1'b1;

        // 6: back-to-back frames
        pat = 16'h1234;
        for (int i = 0; i < 16; i++) beat(i[3:0], pat[i], 1'b0, w);
        pat = 16'hBEEF;
        beat(4'd0, pat[0], 1'b0, w);
        chk("t6_first_beat_wait", w, 1);
        for (int i = 1; i < 16; i++) beat(i[3:0], pat[i], 1'b0, w);
        chk("t6_frame2", bus.output_data, 16'hBEEF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
